rr_switch_scheduler: RTL and testbench

// Packet-level switch scheduler that shares the 5x5 router crossbar among the W/E/N/S/PE input ports.

---
 rtl/rr_switch_scheduler_if.sv | 26 ++
 rtl/rr_switch_scheduler.sv | 140 ++++++++++++++
 tb/tb_rr_switch_scheduler.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_switch_scheduler_if.sv
// Request/grant and crossbar-control bundle between the input buffers, the
// switch scheduler and the 5x5 crossbar.
interface rr_switch_scheduler_if #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3
);
    logic [NUM_PORTS-1:0]        req_valid_i;
    logic [NUM_PORTS*PORT_W-1:0] req_port_i;
    logic [NUM_PORTS-1:0]        req_tail_i;
    logic [NUM_PORTS-1:0]        out_on_i;
    logic [NUM_PORTS-1:0]        in_grant_o;
    logic [NUM_PORTS-1:0]        in_pop_o;
    logic [NUM_PORTS*PORT_W-1:0] out_sel_o;
    logic [NUM_PORTS-1:0]        out_en_o;
    logic                        wdog_err_o;

    modport master (
        output req_valid_i, req_port_i, req_tail_i, out_on_i,
        input  in_grant_o, in_pop_o, out_sel_o, out_en_o, wdog_err_o
    );

    modport slave (
        input  req_valid_i, req_port_i, req_tail_i, out_on_i,
        output in_grant_o, in_pop_o, out_sel_o, out_en_o, wdog_err_o
    );
endinterface

// File: rtl/rr_switch_scheduler.sv
// Packet-level crossbar scheduler: one round-robin arbiter per output, locked to
// the winning input until its tail flit crosses or the lock watchdog fires.
module rr_switch_scheduler #(
    parameter int NUM_PORTS   = 5,
    parameter int PORT_W      = 3,
    parameter int MAX_PKT_LEN = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_switch_scheduler_if.slave  bus
);
    localparam int CW = PORT_W + 1;
    localparam logic [3:0] WDOG_LAST = 4'(MAX_PKT_LEN - 1);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_state_t;

    lock_state_t                 state_r    [NUM_PORTS];
    logic [PORT_W-1:0]           owner_r    [NUM_PORTS];
    logic [PORT_W-1:0]           rr_ptr_r   [NUM_PORTS];
    logic [3:0]                  flit_cnt_r [NUM_PORTS];
    logic [NUM_PORTS-1:0]        in_grant_r;
    logic [NUM_PORTS*PORT_W-1:0] out_sel_r;
    logic                        wdog_err_r;

    logic [NUM_PORTS-1:0] elig_s [NUM_PORTS];
    logic [PORT_W-1:0]    win_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] win_vld_s;
    logic [CW-1:0]        cand_s;
    logic [NUM_PORTS-1:0] pop_s;
    logic [NUM_PORTS-1:0] rel_s;
    logic [NUM_PORTS-1:0] trip_s;
    logic [NUM_PORTS-1:0] in_pop_s;
    logic [NUM_PORTS-1:0] grant_set_s;
    logic [NUM_PORTS-1:0] grant_clr_s;

    // Request matrix: invalid port codes never match, granted inputs are excluded
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                elig_s[o][i] = bus.req_valid_i[i]
                             && (bus.req_port_i[PORT_W*i +: PORT_W] == PORT_W'(o))
                             && !in_grant_r[i];
            end
        end
    end

    // Round-robin pick per output, scanning upward from the slot after rr_ptr
    always_comb begin
        cand_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            win_vld_s[o] = 1'b0;
            win_s[o]     = '0;
            for (int k = 1; k <= NUM_PORTS; k++) begin
                cand_s = {1'b0, rr_ptr_r[o]} + CW'(k);
                if (cand_s >= CW'(NUM_PORTS)) begin
                    cand_s = cand_s - CW'(NUM_PORTS);
                end else begin
                    cand_s = cand_s;
                end
                if (!win_vld_s[o] && elig_s[o][cand_s[PORT_W-1:0]]) begin
                    win_vld_s[o] = 1'b1;
                    win_s[o]     = cand_s[PORT_W-1:0];
                end else begin
                    win_vld_s[o] = win_vld_s[o];
                end
            end
        end
    end

    // Locked datapath: a flit crosses when the owner is valid and downstream is ON
    always_comb begin
        in_pop_s    = '0;
        grant_set_s = '0;
        grant_clr_s = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (state_r[o] == LOCKED) begin
                pop_s[o] = bus.req_valid_i[owner_r[o]] & bus.out_on_i[o];
            end else begin
                pop_s[o] = 1'b0;
            end
            rel_s[o]  = pop_s[o] & bus.req_tail_i[owner_r[o]];
            trip_s[o] = pop_s[o] & ~bus.req_tail_i[owner_r[o]] & (flit_cnt_r[o] == WDOG_LAST);
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_pop_s[i]    = in_pop_s[i] | (pop_s[o] && (owner_r[o] == PORT_W'(i)));
                grant_clr_s[i] = grant_clr_s[i]
                               | ((rel_s[o] | trip_s[o]) && (owner_r[o] == PORT_W'(i)));
                grant_set_s[i] = grant_set_s[i]
                               | ((state_r[o] == IDLE) && win_vld_s[o] && bus.out_on_i[o]
                                  && (win_s[o] == PORT_W'(i)));
            end
        end
    end

    // Per-output lock FSM, grant vector, select fields and watchdog pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                state_r[o]    <= IDLE;
                owner_r[o]    <= '0;
                rr_ptr_r[o]   <= PORT_W'(NUM_PORTS - 1);
                flit_cnt_r[o] <= 4'd0;
            end
            in_grant_r <= '0;
            out_sel_r  <= '0;
            wdog_err_r <= 1'b0;
        end else begin
            in_grant_r <= (in_grant_r & ~grant_clr_s) | grant_set_s;
            wdog_err_r <= |trip_s;
            for (int o = 0; o < NUM_PORTS; o++) begin
                case (state_r[o])
                    IDLE: begin
                        if (win_vld_s[o] && bus.out_on_i[o]) begin
                            state_r[o]                      <= LOCKED;
                            owner_r[o]                      <= win_s[o];
                            out_sel_r[PORT_W*o +: PORT_W]   <= win_s[o];
                            flit_cnt_r[o]                   <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (rel_s[o] || trip_s[o]) begin
                            state_r[o]  <= IDLE;
                            rr_ptr_r[o] <= owner_r[o];
                        end else if (pop_s[o] && (flit_cnt_r[o] != 4'hF)) begin
                            flit_cnt_r[o] <= flit_cnt_r[o] + 4'd1;
                        end
                    end
                    default: state_r[o] <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_grant_o = in_grant_r;
    assign bus.in_pop_o   = in_pop_s;
    assign bus.out_en_o   = pop_s;
    assign bus.out_sel_o  = out_sel_r;
    assign bus.wdog_err_o = wdog_err_r;
endmodule

// File: tb/tb_rr_switch_scheduler.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic compared against a per-output packet-lock reference model.
module tb_rr_switch_scheduler;
    localparam int N   = 5;
    localparam int MAX = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_switch_scheduler_if bus ();
    rr_switch_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    // reference model: owner per output (-1 = free), pointer, flit count, select
    int m_own [N];
    int m_ptr [N];
    int m_cnt [N];
    int m_sel [N];
    bit m_wd;

    typedef struct {
        logic [4:0]  rv;
        logic [14:0] rp;
        logic [4:0]  rt;
        logic [4:0]  on;
        logic [4:0]  grant;
        logic [4:0]  en;
        logic [4:0]  pop;
        logic [14:0] sel;
        logic        wd;
    } vec_t;
    vec_t tbl [16];

    logic [4:0]  r_rv, r_rt, r_on;
    logic [14:0] r_rp;
    int          pops;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int o = 0; o < N; o++) begin
            m_own[o] = -1;
            m_ptr[o] = N - 1;
            m_cnt[o] = 0;
            m_sel[o] = 0;
        end
        m_wd = 1'b0;
    endfunction

    function automatic logic [4:0] model_grant();
        logic [4:0] g = 5'd0;
        for (int o = 0; o < N; o++) if (m_own[o] >= 0) g[m_own[o]] = 1'b1;
        return g;
    endfunction

    function automatic void model_advance(input logic [4:0] rv, input logic [14:0] rp,
                                          input logic [4:0] rt, input logic [4:0] on,
                                          input logic [4:0] g, input logic [4:0] en);
        m_wd = 1'b0;
        for (int o = 0; o < N; o++) begin
            if (m_own[o] < 0) begin
                if (on[o]) begin
                    for (int k = 1; k <= N; k++) begin
                        int i;
                        i = (m_ptr[o] + k) % N;
                        if (rv[i] && (int'(rp[3*i +: 3]) == o) && !g[i]) begin
                            m_own[o] = i;
                            m_sel[o] = i;
                            m_cnt[o] = 0;
                            break;
                        end
                    end
                end
            end else if (en[o]) begin
                m_cnt[o]++;
                if (rt[m_own[o]]) begin
                    m_ptr[o] = m_own[o];
                    m_own[o] = -1;
                end else if (m_cnt[o] == MAX) begin
                    m_ptr[o] = m_own[o];
                    m_own[o] = -1;
                    m_wd     = 1'b1;
                end
            end
        end
    endfunction

    // one clock cycle: drive at negedge, compare against the model, advance the model
    task automatic step(input logic [4:0] rv, input logic [14:0] rp,
                        input logic [4:0] rt, input logic [4:0] on);
        logic [4:0]  eg, een, epop;
        logic [14:0] esel;
        @(negedge clk);
        bus.req_valid_i = rv;
        bus.req_port_i  = rp;
        bus.req_tail_i  = rt;
        bus.out_on_i    = on;
        #1;
        eg   = model_grant();
        een  = 5'd0;
        epop = 5'd0;
        esel = 15'd0;
        for (int o = 0; o < N; o++) begin
            if (m_own[o] >= 0 && rv[m_own[o]] && on[o]) begin
                een[o]          = 1'b1;
                epop[m_own[o]]  = 1'b1;
            end
            esel[3*o +: 3] = 3'(m_sel[o]);
        end
        chk("mdl_grant", 32'(bus.in_grant_o), 32'(eg));
        chk("mdl_en",    32'(bus.out_en_o),   32'(een));
        chk("mdl_pop",   32'(bus.in_pop_o),   32'(epop));
        chk("mdl_sel",   32'(bus.out_sel_o),  32'(esel));
        chk("mdl_wdog",  32'(bus.wdog_err_o), 32'(m_wd));
        model_advance(rv, rp, rt, on, eg, een);
    endtask

    // asynchronous reset between edges; outputs must clear without a clock edge
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(bus.in_grant_o), 32'd0);
        chk("rst_en",    32'(bus.out_en_o),   32'd0);
        chk("rst_pop",   32'(bus.in_pop_o),   32'd0);
        chk("rst_sel",   32'(bus.out_sel_o),  32'd0);
        chk("rst_wdog",  32'(bus.wdog_err_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid_i = 5'd0;
        bus.req_port_i  = 15'd0;
        bus.req_tail_i  = 5'd0;
        bus.out_on_i    = 5'h1F;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got still running expected finished");
        $fatal(1);
    end

    initial begin
        bus.req_valid_i = 5'd0;
        bus.req_port_i  = 15'd0;
        bus.req_tail_i  = 5'd0;
        bus.out_on_i    = 5'h1F;
        model_reset();

        // T1: inputs 0,2,4 -> output 3 with 2-flit packets; T2: 1->0 and 3->4; T4: port 6
        tbl[0]  = '{5'b10101, 15'h30C3, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1'b0};
        tbl[1]  = '{5'b10101, 15'h30C3, 5'b00000, 5'h1F, 5'b00001, 5'b01000, 5'b00001, 15'h0000, 1'b0};
        tbl[2]  = '{5'b10101, 15'h30C3, 5'b00001, 5'h1F, 5'b00001, 5'b01000, 5'b00001, 15'h0000, 1'b0};
        tbl[3]  = '{5'b10100, 15'h30C3, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h0000, 1'b0};
        tbl[4]  = '{5'b10100, 15'h30C3, 5'b00000, 5'h1F, 5'b00100, 5'b01000, 5'b00100, 15'h0400, 1'b0};
        tbl[5]  = '{5'b10100, 15'h30C3, 5'b00100, 5'h1F, 5'b00100, 5'b01000, 5'b00100, 15'h0400, 1'b0};
        tbl[6]  = '{5'b10000, 15'h30C3, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h0400, 1'b0};
        tbl[7]  = '{5'b10000, 15'h30C3, 5'b00000, 5'h1F, 5'b10000, 5'b01000, 5'b10000, 15'h0800, 1'b0};
        tbl[8]  = '{5'b10000, 15'h30C3, 5'b10000, 5'h1F, 5'b10000, 5'b01000, 5'b10000, 15'h0800, 1'b0};
        tbl[9]  = '{5'b00000, 15'h0000, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h0800, 1'b0};
        tbl[10] = '{5'b01010, 15'h0800, 5'b01010, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h0800, 1'b0};
        tbl[11] = '{5'b01010, 15'h0800, 5'b01010, 5'h1F, 5'b01010, 5'b10001, 5'b01010, 15'h3801, 1'b0};
        tbl[12] = '{5'b00000, 15'h0000, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h3801, 1'b0};
        tbl[13] = '{5'b00001, 15'h0006, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h3801, 1'b0};
        tbl[14] = '{5'b00001, 15'h0006, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h3801, 1'b0};
        tbl[15] = '{5'b00001, 15'h0006, 5'b00000, 5'h1F, 5'b00000, 5'b00000, 5'b00000, 15'h3801, 1'b0};

        #2;
        chk("init_grant", 32'(bus.in_grant_o), 32'd0);
        chk("init_en",    32'(bus.out_en_o),   32'd0);
        chk("init_sel",   32'(bus.out_sel_o),  32'd0);
        chk("init_wdog",  32'(bus.wdog_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 16; r++) begin
            step(tbl[r].rv, tbl[r].rp, tbl[r].rt, tbl[r].on);
            chk($sformatf("tbl%0d_grant", r), 32'(bus.in_grant_o), 32'(tbl[r].grant));
            chk($sformatf("tbl%0d_en", r),    32'(bus.out_en_o),   32'(tbl[r].en));
            chk($sformatf("tbl%0d_pop", r),   32'(bus.in_pop_o),   32'(tbl[r].pop));
            chk($sformatf("tbl%0d_sel", r),   32'(bus.out_sel_o),  32'(tbl[r].sel));
            chk($sformatf("tbl%0d_wdog", r),  32'(bus.wdog_err_o), 32'(tbl[r].wd));
        end

        // T3: input 2 locks output 1, downstream OFF for 3 cycles mid-packet
        apply_reset();
        pops = 0;
        step(5'b00100, 15'h0040, 5'b00000, 5'h1F);
        step(5'b00100, 15'h0040, 5'b00000, 5'h1F);
        chk("t3_en_first", 32'(bus.out_en_o), 32'b00010);
        pops += int'(bus.in_pop_o[2]);
        for (int c = 0; c < 3; c++) begin
            step(5'b00100, 15'h0040, 5'b00000, 5'h1D);
            chk("t3_off_pop",   32'(bus.in_pop_o),   32'd0);
            chk("t3_off_en",    32'(bus.out_en_o),   32'd0);
            chk("t3_off_grant", 32'(bus.in_grant_o), 32'b00100);
        end
        step(5'b00100, 15'h0040, 5'b00000, 5'h1F);
        pops += int'(bus.in_pop_o[2]);
        step(5'b00100, 15'h0040, 5'b00100, 5'h1F);
        pops += int'(bus.in_pop_o[2]);
        chk("t3_pops", 32'(pops), 32'd3);
        step(5'b00000, 15'h0000, 5'b00000, 5'h1F);
        chk("t3_released", 32'(bus.in_grant_o), 32'd0);

        // T5: input 4 sends 8 flits to output 2 with no tail; input 0 waits
        apply_reset();
        step(5'b10000, 15'h2000, 5'b00000, 5'h1F);
        for (int p = 1; p <= MAX; p++) begin
            step(5'b10001, 15'h2002, 5'b00000, 5'h1F);
            chk("t5_pop",   32'(bus.in_pop_o),   32'b10000);
            chk("t5_wdog0", 32'(bus.wdog_err_o), 32'd0);
        end
        step(5'b00001, 15'h2002, 5'b00000, 5'h1F);
        chk("t5_wdog_pulse", 32'(bus.wdog_err_o), 32'd1);
        chk("t5_gap_grant",  32'(bus.in_grant_o), 32'd0);
        step(5'b00001, 15'h2002, 5'b00000, 5'h1F);
        chk("t5_next_grant", 32'(bus.in_grant_o), 32'b00001);
        chk("t5_wdog_clear", 32'(bus.wdog_err_o), 32'd0);

        // T6: reset mid-packet restores input 0 priority on output 0
        apply_reset();
        step(5'b00001, 15'h0000, 5'b00001, 5'h1F);
        step(5'b00001, 15'h0000, 5'b00001, 5'h1F);
        chk("t6_first_grant", 32'(bus.in_grant_o), 32'b00001);
        step(5'b00000, 15'h0000, 5'b00000, 5'h1F);
        step(5'b10000, 15'h0000, 5'b00000, 5'h1F);
        step(5'b10000, 15'h0000, 5'b00000, 5'h1F);
        chk("t6_lock4", 32'(bus.out_sel_o[2:0]), 32'd4);
        apply_reset();
        step(5'b10001, 15'h0000, 5'b10001, 5'h1F);
        step(5'b10001, 15'h0000, 5'b10001, 5'h1F);
        chk("t6_after_rst", 32'(bus.in_grant_o), 32'b00001);

        // randomized traffic against the reference model
        apply_reset();
        for (int c = 0; c < 500; c++) begin
            r_rv = 5'($urandom_range(0, 31));
            r_rt = 5'd0;
            r_on = 5'd0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) < 9) r_rp[3*i +: 3] = 3'($urandom_range(0, 4));
                else                          r_rp[3*i +: 3] = 3'($urandom_range(5, 7));
                r_rt[i] = ($urandom_range(0, 3) == 0);
                r_on[i] = ($urandom_range(0, 6) != 0);
            end
            step(r_rv, r_rp, r_rt, r_on);
            if ($urandom_range(0, 149) == 0) apply_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
